// File: rtl/plot_capture_fb.sv
// Framebuffer on the receiving end of the VGA plot interface, with a clear sweep,
// a registered read-back port, saturating plot statistics and a bounding box.
module plot_capture_fb #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          vga_x,
  input  logic [6:0]          vga_y,
  input  logic [COLOUR_W-1:0] vga_colour,
  input  logic                vga_plot,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic                rd_req,
  input  logic [7:0]          rd_x,
  input  logic [6:0]          rd_y,
  output logic                rd_valid,
  output logic [COLOUR_W-1:0] rd_colour,
  output logic [15:0]         plot_count,
  output logic [15:0]         oob_count,
  output logic [15:0]         drop_count,
  output logic [7:0]          bbox_min_x,
  output logic [7:0]          bbox_max_x,
  output logic [6:0]          bbox_min_y,
  output logic [6:0]          bbox_max_y,
  output logic                bbox_valid
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state, state_next;
  logic [14:0] sweep_addr;
  logic [14:0] plot_addr, rd_addr, wr_addr;
  logic [COLOUR_W-1:0] wr_data;
  logic plot_in, rd_in, we, enter_clear;

  logic [COLOUR_W-1:0] mem [0:DEPTH-1];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign plot_in   = (int'(vga_x) < WIDTH) && (int'(vga_y) < HEIGHT);
  assign rd_in     = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
  assign plot_addr = 15'(int'(vga_y) * WIDTH + int'(vga_x));
  assign rd_addr   = 15'(int'(rd_y) * WIDTH + int'(rd_x));

  assign clear_busy  = (state == CLEAR);
  assign enter_clear = (state == IDLE) && clear_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (sweep_addr == LAST_ADDR) state_next = IDLE;
      IDLE:    if (clear_req) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // The sweep owns the write port; plots only reach memory while idle.
  always_comb begin
    we      = 1'b0;
    wr_addr = sweep_addr;
    wr_data = BG_COLOUR;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (vga_plot && plot_in) begin
      we      = 1'b1;
      wr_addr = plot_addr;
      wr_data = vga_colour;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_addr <= '0;
    end else if (state == CLEAR) begin
      sweep_addr <= (sweep_addr == LAST_ADDR) ? 15'd0 : sweep_addr + 15'd1;
    end else if (clear_req) begin
      sweep_addr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Non-blocking memory semantics give read-before-write on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_colour <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_colour <= rd_in ? mem[rd_addr] : BG_COLOUR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plot_count <= '0;
      oob_count  <= '0;
      drop_count <= '0;
      bbox_min_x <= '1;
      bbox_max_x <= '0;
      bbox_min_y <= '1;
      bbox_max_y <= '0;
      bbox_valid <= 1'b0;
    end else if (enter_clear) begin
      plot_count <= '0;
      oob_count  <= '0;
      drop_count <= '0;
      bbox_min_x <= '1;
      bbox_max_x <= '0;
      bbox_min_y <= '1;
      bbox_max_y <= '0;
      bbox_valid <= 1'b0;
    end else if (vga_plot) begin
      if (!plot_in) begin
        oob_count <= sat_inc(oob_count);
      end else if (state == CLEAR) begin
        drop_count <= sat_inc(drop_count);
      end else begin
        plot_count <= sat_inc(plot_count);
        bbox_valid <= 1'b1;
        if (vga_x < bbox_min_x) bbox_min_x <= vga_x;
        if (vga_x > bbox_max_x) bbox_max_x <= vga_x;
        if (vga_y < bbox_min_y) bbox_min_y <= vga_y;
        if (vga_y > bbox_max_y) bbox_max_y <= vga_y;
      end
    end
  end

endmodule
